// File: rtl/uart_pkg.sv
// Shared constants, FSM state types and the baud divisor helper for the
// parametrised UART transceiver.
`timescale 1ns/1ps
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    // Clocks per 16x oversample tick, rounded to nearest.
    function automatic int div_calc(input int clk_hz, input int baud);
        return (clk_hz + 8 * baud) / (16 * baud);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count; a push while
// full is taken only when a pop frees a slot on the same edge.
`timescale 1ns/1ps
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push, do_pop;

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == CW'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr_reg];
    assign count    = count_reg;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/uart_fifo_param.sv
// UART transceiver with RX/TX FIFOs, optional parity and an internal echo
// path from the RX FIFO into the TX FIFO.
`timescale 1ns/1ps
module uart_fifo_param
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY     = 0,
    parameter int ECHO       = 1
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            uart_rx,
    output logic                            uart_tx,
    output logic [DATA_BITS-1:0]            rx_data,
    output logic                            rx_valid,
    input  logic                            rx_ready,
    input  logic [DATA_BITS-1:0]            tx_data,
    input  logic                            tx_valid,
    output logic                            tx_ready,
    output logic [7:0]                      led,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] rx_count,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] tx_count,
    output logic                            frame_err,
    output logic                            parity_err,
    output logic                            overrun,
    input  logic                            err_clr
);
    localparam int   DIV     = div_calc(CLK_HZ, BAUD);
    localparam int   DW      = $clog2(DIV + 1);
    localparam logic PAR_ODD = (PARITY == PARITY_ODD);

    logic [DW-1:0] div_cnt_reg;
    logic          tick;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   div_cnt_reg <= '0;
        else if (tick)  div_cnt_reg <= '0;
        else            div_cnt_reg <= div_cnt_reg + DW'(1);
    end
    assign tick = (div_cnt_reg == DW'(DIV - 1));

    // ---------------- receive path ----------------
    logic [1:0]           rx_sync_reg;
    logic                 rx_prev_reg, rx_line;
    rx_state_t            rx_state_reg, rx_state_next;
    logic [3:0]           rx_tick_reg, rx_tick_next, rx_bit_reg, rx_bit_next;
    logic [DATA_BITS-1:0] rx_shift_reg, rx_shift_next;
    logic                 rx_par_reg, rx_par_next, rx_push_reg, rx_push_next;
    logic                 frame_set, parity_set, overrun_set, rx_sample;
    logic [7:0]           led_reg, led_byte;
    logic                 frame_err_reg, parity_err_reg, overrun_reg;
    logic                 rx_full, rx_empty, rx_fifo_pop;

    assign rx_line   = rx_sync_reg[1];
    assign rx_sample = tick && (rx_tick_reg == 4'd15);

    always_comb begin
        rx_state_next = rx_state_reg;
        rx_tick_next  = rx_tick_reg;
        rx_bit_next   = rx_bit_reg;
        rx_shift_next = rx_shift_reg;
        rx_par_next   = rx_par_reg;
        rx_push_next  = 1'b0;
        frame_set     = 1'b0;
        parity_set    = 1'b0;
        if (tick) rx_tick_next = rx_tick_reg + 4'd1;
        case (rx_state_reg)
            RX_IDLE: begin
                rx_tick_next = '0;
                if (rx_prev_reg && !rx_line) rx_state_next = RX_START;
            end
            RX_START: begin
                // Re-check at the start-bit midpoint; a high line was a glitch.
                if (tick && rx_tick_reg == 4'd7) begin
                    rx_tick_next  = '0;
                    rx_bit_next   = '0;
                    rx_state_next = rx_line ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_sample) begin
                    rx_shift_next = {rx_line, rx_shift_reg[DATA_BITS-1:1]};
                    rx_bit_next   = rx_bit_reg + 4'd1;
                    if (rx_bit_reg == 4'(DATA_BITS - 1))
                        rx_state_next = (PARITY == PARITY_NONE) ? RX_STOP : RX_PARITY;
                end
            end
            RX_PARITY: begin
                if (rx_sample) begin
                    rx_par_next   = rx_line;
                    rx_state_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_sample) begin
                    rx_state_next = RX_IDLE;
                    if (!rx_line)
                        frame_set = 1'b1;
                    else if (PARITY != PARITY_NONE && (rx_par_reg != ((^rx_shift_reg) ^ PAR_ODD)))
                        parity_set = 1'b1;
                    else
                        rx_push_next = 1'b1;
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_led
            if (gi < DATA_BITS) begin : g_bit
                assign led_byte[gi] = rx_shift_reg[gi];
            end else begin : g_zero
                assign led_byte[gi] = 1'b0;
            end
        end
    endgenerate

    assign overrun_set = rx_push_reg && rx_full && !rx_fifo_pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_sync_reg    <= 2'b11;
            rx_prev_reg    <= 1'b1;
            rx_state_reg   <= RX_IDLE;
            rx_tick_reg    <= '0;
            rx_bit_reg     <= '0;
            rx_shift_reg   <= '0;
            rx_par_reg     <= 1'b0;
            rx_push_reg    <= 1'b0;
            led_reg        <= '0;
            frame_err_reg  <= 1'b0;
            parity_err_reg <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            rx_sync_reg    <= {rx_sync_reg[0], uart_rx};
            rx_prev_reg    <= rx_line;
            rx_state_reg   <= rx_state_next;
            rx_tick_reg    <= rx_tick_next;
            rx_bit_reg     <= rx_bit_next;
            rx_shift_reg   <= rx_shift_next;
            rx_par_reg     <= rx_par_next;
            rx_push_reg    <= rx_push_next;
            if (rx_push_reg) led_reg <= led_byte;
            // A new error outranks a simultaneous clear.
            frame_err_reg  <= (frame_err_reg  && !err_clr) || frame_set;
            parity_err_reg <= (parity_err_reg && !err_clr) || parity_set;
            overrun_reg    <= (overrun_reg    && !err_clr) || overrun_set;
        end
    end

    // ---------------- FIFOs and echo routing ----------------
    logic [DATA_BITS-1:0] rx_head, tx_head, tx_fifo_data;
    logic                 tx_full, tx_empty, tx_fifo_push, tx_fifo_pop;

    assign rx_fifo_pop  = (ECHO != 0) ? (!rx_empty && !tx_full) : (rx_ready && !rx_empty);
    assign tx_fifo_push = (ECHO != 0) ? rx_fifo_pop : tx_valid;
    assign tx_fifo_data = (ECHO != 0) ? rx_head : tx_data;

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .reset_n(reset_n),
        .push(rx_push_reg), .push_data(rx_shift_reg),
        .pop(rx_fifo_pop), .pop_data(rx_head),
        .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .reset_n(reset_n),
        .push(tx_fifo_push), .push_data(tx_fifo_data),
        .pop(tx_fifo_pop), .pop_data(tx_head),
        .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    // ---------------- transmit path ----------------
    tx_state_t            tx_state_reg, tx_state_next;
    logic [3:0]           tx_tick_reg, tx_tick_next, tx_bit_reg, tx_bit_next;
    logic [DATA_BITS-1:0] tx_shift_reg, tx_shift_next;
    logic                 tx_par_reg, tx_par_next, tx_line, uart_tx_reg, tx_last_tick;

    assign tx_last_tick = tick && (tx_tick_reg == 4'd15);

    always_comb begin
        tx_state_next = tx_state_reg;
        tx_tick_next  = tx_tick_reg;
        tx_bit_next   = tx_bit_reg;
        tx_shift_next = tx_shift_reg;
        tx_par_next   = tx_par_reg;
        tx_fifo_pop   = 1'b0;
        tx_line       = 1'b1;
        if (tick) tx_tick_next = tx_tick_reg + 4'd1;
        case (tx_state_reg)
            TX_START: begin
                tx_line = 1'b0;
                if (tx_last_tick) begin
                    tx_state_next = TX_DATA;
                    tx_bit_next   = '0;
                end
            end
            TX_DATA: begin
                tx_line = tx_shift_reg[0];
                if (tx_last_tick) begin
                    tx_shift_next = tx_shift_reg >> 1;
                    tx_bit_next   = tx_bit_reg + 4'd1;
                    if (tx_bit_reg == 4'(DATA_BITS - 1))
                        tx_state_next = (PARITY == PARITY_NONE) ? TX_STOP : TX_PARITY;
                end
            end
            TX_PARITY: begin
                tx_line = tx_par_reg;
                if (tx_last_tick) tx_state_next = TX_STOP;
            end
            TX_STOP: begin
                if (tx_last_tick) tx_state_next = TX_IDLE;
            end
            default: tx_state_next = TX_IDLE;
        endcase
        // Loading straight from the stop bit keeps back-to-back frames gapless.
        if ((tx_state_reg == TX_IDLE || (tx_state_reg == TX_STOP && tx_last_tick)) && !tx_empty) begin
            tx_fifo_pop   = 1'b1;
            tx_state_next = TX_START;
            tx_tick_next  = '0;
            tx_shift_next = tx_head;
            tx_par_next   = (^tx_head) ^ PAR_ODD;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_reg <= TX_IDLE;
            tx_tick_reg  <= '0;
            tx_bit_reg   <= '0;
            tx_shift_reg <= '0;
            tx_par_reg   <= 1'b0;
            uart_tx_reg  <= 1'b1;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_tick_reg  <= tx_tick_next;
            tx_bit_reg   <= tx_bit_next;
            tx_shift_reg <= tx_shift_next;
            tx_par_reg   <= tx_par_next;
            uart_tx_reg  <= tx_line;
        end
    end

    assign uart_tx    = uart_tx_reg;
    assign rx_data    = rx_head;
    assign rx_valid   = (ECHO != 0) ? 1'b0 : !rx_empty;
    assign tx_ready   = (ECHO != 0) ? 1'b0 : !tx_full;
    assign led        = led_reg;
    assign frame_err  = frame_err_reg;
    assign parity_err = parity_err_reg;
    assign overrun    = overrun_reg;

endmodule

// File: tb/tb_uart_fifo_param.sv
// Directed bench: echo instance at default rates, plus fast parity and host
// instances sharing one clock.
`timescale 1ns/1ps
module tb_uart_fifo_param;

    localparam int BIT_E = 8640;   // 432 clk per bit at defaults
    localparam int BIT_F = 1280;   // 64 clk per bit at BAUD 781250

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic       rst_e, rst_p, rst_h;
    logic       rx_e, rx_p, rx_h;
    logic       tx_e, tx_p, tx_h;
    logic [7:0] rxd_e, rxd_p, rxd_h, txd_e, txd_p, txd_h, led_e, led_p, led_h;
    logic       rxv_e, rxv_p, rxv_h, rdy_e, rdy_p, rdy_h;
    logic       txv_e, txv_p, txv_h, txr_e, txr_p, txr_h;
    logic [4:0] rxc_e, rxc_p, rxc_h, txc_e, txc_p, txc_h;
    logic       fe_e, fe_p, fe_h, pe_e, pe_p, pe_h, ov_e, ov_p, ov_h;
    logic       clr_e, clr_p, clr_h;

    uart_fifo_param u_echo (
        .clk(clk), .reset_n(rst_e), .uart_rx(rx_e), .uart_tx(tx_e),
        .rx_data(rxd_e), .rx_valid(rxv_e), .rx_ready(rdy_e),
        .tx_data(txd_e), .tx_valid(txv_e), .tx_ready(txr_e), .led(led_e),
        .rx_count(rxc_e), .tx_count(txc_e), .frame_err(fe_e),
        .parity_err(pe_e), .overrun(ov_e), .err_clr(clr_e)
    );

    uart_fifo_param #(.BAUD(781250), .PARITY(1), .ECHO(0)) u_par (
        .clk(clk), .reset_n(rst_p), .uart_rx(rx_p), .uart_tx(tx_p),
        .rx_data(rxd_p), .rx_valid(rxv_p), .rx_ready(rdy_p),
        .tx_data(txd_p), .tx_valid(txv_p), .tx_ready(txr_p), .led(led_p),
        .rx_count(rxc_p), .tx_count(txc_p), .frame_err(fe_p),
        .parity_err(pe_p), .overrun(ov_p), .err_clr(clr_p)
    );

    uart_fifo_param #(.BAUD(781250), .ECHO(0)) u_host (
        .clk(clk), .reset_n(rst_h), .uart_rx(rx_h), .uart_tx(tx_h),
        .rx_data(rxd_h), .rx_valid(rxv_h), .rx_ready(rdy_h),
        .tx_data(txd_h), .tx_valid(txv_h), .tx_ready(txr_h), .led(led_h),
        .rx_count(rxc_h), .tx_count(txc_h), .frame_err(fe_h),
        .parity_err(pe_h), .overrun(ov_h), .err_clr(clr_h)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("vector %0d %s observed %h expected %h", vectors, tag, obs, exp);
    endtask

    task automatic set_rx(input int sel, input logic v);
        case (sel)
            0:       rx_e = v;
            1:       rx_p = v;
            default: rx_h = v;
        endcase
    endtask

    function automatic logic tx_of(input int sel);
        case (sel)
            0:       return tx_e;
            1:       return tx_p;
            default: return tx_h;
        endcase
    endfunction

    // par < 0 means no parity bit is sent.
    task automatic send_frame(input int sel, input logic [7:0] d, input int par,
                              input logic stop, input int bit_ns);
        set_rx(sel, 1'b0);
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            set_rx(sel, d[i]);
            #(bit_ns);
        end
        if (par >= 0) begin
            set_rx(sel, par[0]);
            #(bit_ns);
        end
        set_rx(sel, stop);
        #(bit_ns);
        set_rx(sel, 1'b1);
    endtask

    task automatic capture_frame(input int sel, input int bit_ns, output logic [7:0] data,
                                 output logic stop_bit, output time t_start);
        int n = 0;
        data = '0;
        while (tx_of(sel) !== 1'b0 && n < 40000) begin
            @(negedge clk);
            n++;
        end
        check("tx_start_seen", {15'd0, tx_of(sel)}, 16'd0);
        t_start = $time;
        #(bit_ns / 2);
        for (int i = 0; i < 8; i++) begin
            #(bit_ns);
            data[i] = tx_of(sel);
        end
        #(bit_ns);
        stop_bit = tx_of(sel);
    endtask

    task automatic wait_clks(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    logic [7:0] d1, d2, d3;
    logic       s1, s2, s3, saw_low;
    time        t1, t2, t3;

    initial begin
        rst_e = 0; rst_p = 0; rst_h = 0;
        rx_e = 1; rx_p = 1; rx_h = 1;
        rdy_e = 0; rdy_p = 0; rdy_h = 0;
        txd_e = 0; txd_p = 0; txd_h = 0;
        txv_e = 0; txv_p = 0; txv_h = 0;
        clr_e = 0; clr_p = 0; clr_h = 0;
        wait_clks(5);
        rst_e = 1; rst_p = 1; rst_h = 1;
        wait_clks(3);

        // Reset state
        check("rst_uart_tx", {15'd0, tx_e}, 16'd1);
        check("rst_led", {8'd0, led_e}, 16'h0000);
        check("rst_rx_valid", {15'd0, rxv_h}, 16'd0);
        check("rst_counts", {3'd0, rxc_e, 3'd0, txc_e}, 16'h0000);
        check("rst_err_flags", {13'd0, fe_e, pe_e, ov_e}, 16'd0);
        check("rst_tx_ready_echo", {15'd0, txr_e}, 16'd0);
        check("rst_tx_ready_host", {15'd0, txr_h}, 16'd1);

        // Echo of a single 'A'
        fork
            send_frame(0, 8'h41, -1, 1'b1, BIT_E);
            capture_frame(0, BIT_E, d1, s1, t1);
        join
        wait_clks(5);
        check("echo_led", {8'd0, led_e}, 16'h0041);
        check("echo_tx_data", {8'd0, d1}, 16'h0041);
        check("echo_tx_stop", {15'd0, s1}, 16'd1);
        check("echo_frame_err", {15'd0, fe_e}, 16'd0);
        check("echo_tx_count", {11'd0, txc_e}, 16'd0);

        // Back-to-back echo: second start must follow first by one frame
        fork
            begin
                send_frame(0, 8'h41, -1, 1'b1, BIT_E);
                send_frame(0, 8'h42, -1, 1'b1, BIT_E);
            end
            begin
                capture_frame(0, BIT_E, d1, s1, t1);
                capture_frame(0, BIT_E, d2, s2, t2);
            end
        join
        wait_clks(5);
        check("b2b_first", {8'd0, d1}, 16'h0041);
        check("b2b_second", {8'd0, d2}, 16'h0042);
        check("b2b_stops", {14'd0, s1, s2}, 16'd3);
        check("b2b_spacing", {15'd0, ((t2 - t1) * 2 > 19 * BIT_E) && ((t2 - t1) * 2 < 21 * BIT_E)}, 16'd1);
        check("b2b_led", {8'd0, led_e}, 16'h0042);

        // Even parity instance
        send_frame(1, 8'h42, 0, 1'b1, BIT_F);
        wait_clks(4);
        check("par_good_led", {8'd0, led_p}, 16'h0042);
        check("par_good_flags", {14'd0, pe_p, fe_p}, 16'd0);
        check("par_good_count", {11'd0, rxc_p}, 16'd1);
        send_frame(1, 8'h42, 1, 1'b1, BIT_F);
        wait_clks(4);
        check("par_bad_err", {15'd0, pe_p}, 16'd1);
        check("par_bad_count", {11'd0, rxc_p}, 16'd1);
        send_frame(1, 8'h43, 0, 1'b1, BIT_F);
        wait_clks(4);
        check("par_bad_led_kept", {8'd0, led_p}, 16'h0042);
        check("par_bad_count2", {11'd0, rxc_p}, 16'd1);

        // Low stop bit
        send_frame(1, 8'h55, 0, 1'b0, BIT_F);
        wait_clks(4);
        check("frame_err_set", {15'd0, fe_p}, 16'd1);
        check("frame_err_no_push", {11'd0, rxc_p}, 16'd1);
        check("frame_err_led_kept", {8'd0, led_p}, 16'h0042);
        @(negedge clk); clr_p = 1;
        @(negedge clk); clr_p = 0;
        check("err_clr_frame", {15'd0, fe_p}, 16'd0);
        check("err_clr_parity", {15'd0, pe_p}, 16'd0);

        // Host RX overrun: 17 bytes into a 16-deep FIFO
        for (int i = 0; i < 17; i++) send_frame(2, 8'h10 + 8'(i), -1, 1'b1, BIT_F);
        wait_clks(4);
        check("ovr_count", {11'd0, rxc_h}, 16'd16);
        check("ovr_flag", {15'd0, ov_h}, 16'd1);
        check("ovr_head", {8'd0, rxd_h}, 16'h0010);
        check("ovr_valid", {15'd0, rxv_h}, 16'd1);
        check("ovr_led_last", {8'd0, led_h}, 16'h0020);
        rdy_h = 1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("pop_%0d", i), {8'd0, rxd_h}, {8'd0, 8'h10 + 8'(i)});
            @(negedge clk);
        end
        rdy_h = 0;
        check("pop_all_valid", {15'd0, rxv_h}, 16'd0);
        check("pop_all_count", {11'd0, rxc_h}, 16'd0);

        // Host TX: three pushes on consecutive edges
        txv_h = 1; txd_h = 8'hA5;
        @(negedge clk); txd_h = 8'h3C;
        @(negedge clk); txd_h = 8'h96;
        @(negedge clk); txv_h = 0;
        check("tx_count_after_push", {11'd0, txc_h}, 16'd2);
        check("tx_start_latency", {15'd0, tx_h}, 16'd0);
        capture_frame(2, BIT_F, d1, s1, t1);
        capture_frame(2, BIT_F, d2, s2, t2);
        capture_frame(2, BIT_F, d3, s3, t3);
        check("tx_frame0", {8'd0, d1}, 16'h00A5);
        check("tx_frame1", {8'd0, d2}, 16'h003C);
        check("tx_frame2", {8'd0, d3}, 16'h0096);
        check("tx_stops", {13'd0, s1, s2, s3}, 16'd7);

        // Reset in the middle of the second frame
        wait_clks(100);
        txv_h = 1; txd_h = 8'h11;
        @(negedge clk); txd_h = 8'h22;
        @(negedge clk); txd_h = 8'h33;
        @(negedge clk); txv_h = 0;
        capture_frame(2, BIT_F, d1, s1, t1);
        check("rst_frame0", {8'd0, d1}, 16'h0011);
        for (int n = 0; n < 4000 && tx_h !== 1'b0; n++) @(negedge clk);
        #(3 * BIT_F + BIT_F / 2);
        @(negedge clk);
        #5;
        check("mid_frame_line_low", {15'd0, tx_h}, 16'd0);
        rst_h = 0;
        #1;
        check("async_reset_tx_high", {15'd0, tx_h}, 16'd1);
        wait_clks(5);
        rst_h = 1;
        wait_clks(2);
        check("rst_tx_count", {11'd0, txc_h}, 16'd0);
        saw_low = 1'b0;
        for (int i = 0; i < 12 * 64; i++) begin
            @(negedge clk);
            if (tx_h !== 1'b1) saw_low = 1'b1;
        end
        check("tx_quiet_after_reset", {15'd0, saw_low}, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_fifo_param.md
# uart_fifo_param

Parametrised UART transceiver with receive and transmit FIFOs, configurable frame format and an internal echo mode. It is the next-generation replacement for the fixed 8N1/115200 UART-FIFO board block. It sits between the board UART pins and either an internal loopback path (echo mode) or a host valid/ready interface. It also drives the board LEDs with the last good received byte.

## Interface
- CLK_HZ, 50_000_000, system clock frequency
- BAUD, 115200, line rate
- DATA_BITS, 8, data bits per frame (5..9)
- FIFO_DEPTH, 16, entries per FIFO (power of 2, ≥2)
- PARITY, 0, 0 none / 1 even / 2 odd
- ECHO, 1, 1 = RX FIFO drains into TX FIFO internally; 0 = host interface
- clk  in  1  system clock; single clock domain
- reset_n  in  1  asynchronous, active-low reset
- uart_rx  in  1  serial input, idle high, asynchronous to clk
- uart_tx  out  1  serial output, idle high
- rx_data  out  DATA_BITS  RX FIFO head, first-word-fall-through
- rx_valid  out  1  RX FIFO not empty; forced 0 when ECHO=1
- rx_ready  in  1  pop RX FIFO when rx_valid && rx_ready
- tx_data  in  DATA_BITS  byte to transmit
- tx_valid  in  1  push request
- tx_ready  out  1  TX FIFO not full; forced 0 when ECHO=1
- led  out  8  last good RX byte, low 8 bits, zero-extended
- rx_count, tx_count  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy
- frame_err, parity_err, overrun  out  1  sticky error flags
- err_clr  in  1  synchronous clear of all sticky flags

## Operation
- Oversample tick: DIV = round(CLK_HZ/(16·BAUD)); defaults give 27, i.e. 432 clk per bit.
- RX path: 2-flop synchroniser on uart_rx. FSM RX_IDLE → RX_START → RX_DATA → RX_PARITY (skipped if PARITY=0) → RX_STOP → RX_IDLE.
- RX start: falling edge starts RX_START. The line is re-sampled at tick 8. If it is high, the start is a glitch and the FSM returns to RX_IDLE.
- RX bits: each subsequent bit is sampled at its 16-tick midpoint. LSB first.
- RX errors: a low stop bit sets frame_err and discards the byte. A parity mismatch sets parity_err and discards the byte.
- RX push: a good byte is pushed to the RX FIFO and loaded into led. If the FIFO is full with no pop in the same cycle, the byte is dropped, overrun is set, and led is still updated.
- TX path: FSM TX_IDLE → TX_START → TX_DATA → TX_PARITY (optional) → TX_STOP → TX_IDLE. Each state lasts 16 ticks.
- TX pops when TX_IDLE and the FIFO is not empty. Back-to-back frames have no idle gap beyond the 1 stop bit.
- Echo: whenever RX FIFO not empty and TX FIFO not full, 1 entry moves per cycle. The host ports are ignored.
- FIFOs: push when full is accepted only if a pop occurs in the same cycle. Pop when empty is ignored. Pointers wrap modulo FIFO_DEPTH.
- err_clr and a new error in the same cycle: the error wins and the flag stays 1.

## Timing
- Reset values: uart_tx=1, led=0, rx_valid=0, counts=0, all error flags 0, both FSMs idle, FIFOs empty.
- tx_ready after reset: 1 if ECHO=0, 0 if ECHO=1.
- Reset asserted mid-frame: uart_tx goes high asynchronously and the partial frame is abandoned.
- RX latency: FIFO write 1 clk after the stop-bit mid-sample; rx_valid and led update on the following clk edge.
- TX latency: start bit drives uart_tx 2 clk after the push into an empty TX FIFO while TX_IDLE.
- Echo latency: uart_tx falls ≤4 clk after the RX stop-bit mid-sample when TX is idle.
- rx_count and tx_count reflect the push/pop of the previous edge.

## Structure
- Package uart_pkg: parity mode constants, RX/TX state enums, divisor function div_calc(clk_hz, baud).
- Sub-module uart_sync_fifo (WIDTH, DEPTH): FWFT, count output, instantiated for RX and TX.
- RX/TX FSMs, tick generator and echo mux live in the top module.

## Test plan
- Defaults, ECHO=1:
  - Send 'A' 0x41 at 8640 ns/bit → led=0x41; uart_tx emits 0x41 8N1 frame; frame_err=0.
  - Send 0x41 then 0x42 back-to-back → uart_tx emits 0x41 then 0x42 frames with no gap between stop and start; led=0x42.
- PARITY=1: send 0x42 with parity bit 0 → accepted, led=0x42. Send 0x42 with parity bit 1 → parity_err=1, led unchanged.
- Stop bit driven low on 0x55 → frame_err=1, nothing pushed. err_clr pulse → frame_err=0.
- ECHO=0, rx_ready=0: send 17 bytes → rx_count=16, overrun=1, rx_data=first byte. Popping all 16 returns them in order.
- ECHO=0: push 3 bytes via tx_valid → 3 frames serialised. Assert reset_n=0 mid-second frame → uart_tx=1 immediately, tx_count=0 after release.
